tlb: RTL

TLB -- requirements
Module: tlb

---
 rtl/tlb_pkg.sv | 29 ++
 rtl/tlb_cam.sv | 78 +++++++
 rtl/tlb.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// Shared types and widths for the TLB: state encoding, entry layout and
// Sv32 address/PTE field widths.
package tlb_pkg;

  localparam int unsigned VA_W      = 32;
  localparam int unsigned PA_W      = 32;
  localparam int unsigned PTE_W     = 32;
  localparam int unsigned OFF_W     = 12;
  localparam int unsigned VPN_W     = VA_W - OFF_W;   // 20
  localparam int unsigned PPN_W     = 22;             // Sv32 PPN in pte[31:10]
  localparam int unsigned PPN_LSB   = 10;
  localparam int unsigned PA_PPN_W  = PA_W - OFF_W;   // PPN bits that fit the 32-bit paddr
  localparam int unsigned PTE_V_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_PTW_REQ  = 3'd2,
    S_PTW_WAIT = 3'd3,
    S_RESPOND  = 3'd4
  } tlb_state_e;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] tag;
    logic [PPN_W-1:0] ppn;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_cam.sv
// Fully-associative entry store: registered parallel tag compare,
// round-robin fill and (with TLB_FLUSH_EN) a whole-array flush.
module tlb_cam
  import tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VPN_W-1:0] lookup_vpn_i,
  output logic             hit_o,
  output logic [PPN_W-1:0] hit_ppn_o,
  input  logic             fill_en_i,
  input  logic [VPN_W-1:0] fill_vpn_i,
  input  logic [PPN_W-1:0] fill_ppn_i
`ifdef TLB_FLUSH_EN
  ,
  input  logic             flush_i
`endif
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  tlb_entry_t       entries_q [ENTRIES];
  logic [IDX_W-1:0] victim_q;
  logic             hit_q;
  logic [PPN_W-1:0] hit_ppn_q;
  logic             hit_c;
  logic [PPN_W-1:0] hit_ppn_c;
  logic             flush_c;

`ifdef TLB_FLUSH_EN
  assign flush_c = flush_i;
`else
  assign flush_c = 1'b0;
`endif

  // Parallel tag compare; at most one entry can match, so OR-merging is exact
  always_comb begin
    hit_c     = 1'b0;
    hit_ppn_c = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (entries_q[i].valid && (entries_q[i].tag == lookup_vpn_i)) begin
        hit_c     = 1'b1;
        hit_ppn_c = hit_ppn_c | entries_q[i].ppn;
      end
    end
  end

  // Register the compare result so the wide match tree gets a full cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q     <= 1'b0;
      hit_ppn_q <= '0;
    end else begin
      hit_q     <= hit_c && !flush_c;
      hit_ppn_q <= hit_ppn_c;
    end
  end

  // Entry array and victim pointer; a flush overrides a same-cycle fill
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      victim_q <= '0;
    end else if (flush_c) begin
      for (int unsigned i = 0; i < ENTRIES; i++) entries_q[i].valid <= 1'b0;
      victim_q <= '0;
    end else if (fill_en_i) begin
      entries_q[victim_q] <= '{valid: 1'b1, tag: fill_vpn_i, ppn: fill_ppn_i};
      victim_q            <= victim_q + IDX_W'(1);
    end
  end

  assign hit_o     = hit_q;
  assign hit_ppn_o = hit_ppn_q;

endmodule

// File: rtl/tlb.sv
// Single-outstanding fully-associative TLB with a page-table-walker port.
// Optional feature macro: TLB_FLUSH_EN adds flush_i (invalidate all entries).
module tlb
  import tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [VA_W-1:0]  req_vaddr_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [PA_W-1:0]  resp_paddr_o,
  output logic             resp_fault_o,
  output logic             ptw_req_valid_o,
  input  logic             ptw_req_ready_i,
  output logic [VA_W-1:0]  ptw_vaddr_o,
  input  logic             ptw_resp_valid_i,
  output logic             ptw_resp_ready_o,
  input  logic [PTE_W-1:0] ptw_pte_i
`ifdef TLB_FLUSH_EN
  ,
  input  logic             flush_i
`endif
);

  tlb_state_e       state_q, state_d;
  logic             lkp_q, lkp_d;               // second LOOKUP cycle
  logic             flush_seen_q, flush_seen_d; // flush observed during this walk
  logic [VA_W-1:0]  vaddr_q, vaddr_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [PA_W-1:0]  resp_paddr_q, resp_paddr_d;
  logic             resp_fault_q, resp_fault_d;
  logic             ptw_req_valid_q, ptw_req_valid_d;
  logic [VA_W-1:0]  ptw_vaddr_q, ptw_vaddr_d;
  logic             ptw_resp_ready_q, ptw_resp_ready_d;

  logic             fill_en_c;
  logic             cam_hit;
  logic [PPN_W-1:0] cam_hit_ppn;
  logic             flush_c;
  logic             unused_c;

`ifdef TLB_FLUSH_EN
  assign flush_c = flush_i;
`else
  assign flush_c = 1'b0;
`endif

  // PTE flag bits and upper PPN bits beyond the 32-bit paddr are not consumed
  assign unused_c = ^{ptw_pte_i[PPN_LSB-1:1], cam_hit_ppn[PPN_W-1:PA_PPN_W]};

  tlb_cam #(
    .ENTRIES (ENTRIES)
  ) u_cam (
    .clk          (clk),
    .rst          (rst),
    .lookup_vpn_i (vaddr_q[VA_W-1:OFF_W]),
    .hit_o        (cam_hit),
    .hit_ppn_o    (cam_hit_ppn),
    .fill_en_i    (fill_en_c),
    .fill_vpn_i   (vaddr_q[VA_W-1:OFF_W]),
    .fill_ppn_i   (ptw_pte_i[PTE_W-1:PPN_LSB])
`ifdef TLB_FLUSH_EN
    ,
    .flush_i      (flush_c)
`endif
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      lkp_q            <= 1'b0;
      flush_seen_q     <= 1'b0;
      vaddr_q          <= '0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_paddr_q     <= '0;
      resp_fault_q     <= 1'b0;
      ptw_req_valid_q  <= 1'b0;
      ptw_vaddr_q      <= '0;
      ptw_resp_ready_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      lkp_q            <= lkp_d;
      flush_seen_q     <= flush_seen_d;
      vaddr_q          <= vaddr_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_paddr_q     <= resp_paddr_d;
      resp_fault_q     <= resp_fault_d;
      ptw_req_valid_q  <= ptw_req_valid_d;
      ptw_vaddr_q      <= ptw_vaddr_d;
      ptw_resp_ready_q <= ptw_resp_ready_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d          = state_q;
    lkp_d            = lkp_q;
    flush_seen_d     = flush_seen_q;
    vaddr_d          = vaddr_q;
    req_ready_d      = req_ready_q;
    resp_valid_d     = resp_valid_q;
    resp_paddr_d     = resp_paddr_q;
    resp_fault_d     = resp_fault_q;
    ptw_req_valid_d  = ptw_req_valid_q;
    ptw_vaddr_d      = ptw_vaddr_q;
    ptw_resp_ready_d = ptw_resp_ready_q;
    fill_en_c        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          vaddr_d      = req_vaddr_i;
          req_ready_d  = 1'b0;
          lkp_d        = 1'b0;
          flush_seen_d = 1'b0;
          state_d      = S_LOOKUP;
        end
      end

      // First cycle lets the CAM register its compare; second cycle decides
      S_LOOKUP: begin
        if (!lkp_q) begin
          lkp_d = 1'b1;
        end else if (cam_hit && !flush_c) begin
          resp_valid_d = 1'b1;
          resp_paddr_d = {cam_hit_ppn[PA_PPN_W-1:0], vaddr_q[OFF_W-1:0]};
          resp_fault_d = 1'b0;
          state_d      = S_RESPOND;
        end else begin
          ptw_req_valid_d = 1'b1;
          ptw_vaddr_d     = vaddr_q;
          state_d         = S_PTW_REQ;
        end
      end

      S_PTW_REQ: begin
        if (flush_c) flush_seen_d = 1'b1;
        if (ptw_req_ready_i) begin
          ptw_req_valid_d  = 1'b0;
          ptw_resp_ready_d = 1'b1;
          state_d          = S_PTW_WAIT;
        end
      end

      // A flush since the walk started makes the returned PTE stale: no fill
      S_PTW_WAIT: begin
        if (flush_c) flush_seen_d = 1'b1;
        if (ptw_resp_valid_i) begin
          ptw_resp_ready_d = 1'b0;
          resp_valid_d     = 1'b1;
          state_d          = S_RESPOND;
          if (ptw_pte_i[PTE_V_BIT]) begin
            fill_en_c    = !flush_seen_q;
            resp_paddr_d = {ptw_pte_i[PPN_LSB +: PA_PPN_W], vaddr_q[OFF_W-1:0]};
            resp_fault_d = 1'b0;
          end else begin
            resp_paddr_d = '0;
            resp_fault_d = 1'b1;
          end
        end
      end

      S_RESPOND: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d          = S_IDLE;
        req_ready_d      = 1'b1;
        resp_valid_d     = 1'b0;
        ptw_req_valid_d  = 1'b0;
        ptw_resp_ready_d = 1'b0;
      end
    endcase
  end

  assign req_ready_o      = req_ready_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_paddr_o     = resp_paddr_q;
  assign resp_fault_o     = resp_fault_q;
  assign ptw_req_valid_o  = ptw_req_valid_q;
  assign ptw_vaddr_o      = ptw_vaddr_q;
  assign ptw_resp_ready_o = ptw_resp_ready_q;

endmodule
